// File: rtl/proc_dpath_alu_iter_if.sv
// proc_dpath_alu_iter_if: val/rdy request/response bundle for the iterative ALU.
interface proc_dpath_alu_iter_if #(parameter int p_nbits = 32);
  logic               req_val;
  logic               req_rdy;
  logic [4:0]         req_fn;
  logic [p_nbits-1:0] req_in0;
  logic [p_nbits-1:0] req_in1;
  logic               resp_val;
  logic               resp_rdy;
  logic [p_nbits-1:0] resp_out;
  logic               resp_eq;
  logic               resp_lt;
  logic               resp_ltu;
  modport master (
    output req_val, req_fn, req_in0, req_in1, resp_rdy,
    input  req_rdy, resp_val, resp_out, resp_eq, resp_lt, resp_ltu
  );
  modport slave (
    input  req_val, req_fn, req_in0, req_in1, resp_rdy,
    output req_rdy, resp_val, resp_out, resp_eq, resp_lt, resp_ltu
  );
endinterface

// File: rtl/proc_dpath_alu_iter.sv
// proc_dpath_alu_iter: multi-cycle ALU with single-cycle ops plus iterative RV32M multiply/divide.
module proc_dpath_alu_iter #(
  parameter int p_nbits = 32
) (
  input logic                  clk,
  input logic                  reset,
  proc_dpath_alu_iter_if.slave io
);
  localparam int N  = p_nbits;
  localparam int SW = $clog2(p_nbits);
  localparam int CW = $clog2(p_nbits + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t         state_q;
  logic           rdy_q;
  logic [CW-1:0]  cnt_q;
  logic [4:0]     fn_q;
  logic [N-1:0]   in0_q;
  logic [N-1:0]   b_q;
  logic [2*N-1:0] p_q;
  logic           mul_q;
  logic           nq_q;
  logic           nr_q;
  logic           dz_q;
  logic [N-1:0]   out_q;
  logic           eq_q;
  logic           lt_q;
  logic           ltu_q;
  logic [N-1:0]   in0;
  logic [N-1:0]   in1;
  logic [4:0]     fn;
  logic [SW-1:0]  sh;
  logic [N-1:0]   sum;
  logic           eq;
  logic           lt;
  logic           ltu;
  logic [N-1:0]   alu_d;
  logic           is_iter;
  logic           is_mul;
  logic           s0;
  logic           s1;
  logic [N-1:0]   mag0;
  logic [N-1:0]   mag1;
  logic [N:0]     madd;
  logic [N:0]     rsh;
  logic [N:0]     rdiff;
  logic [2*N-1:0] p_d;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo;
  logic [N-1:0]   rem;
  logic [N-1:0]   fin_d;
  assign in0     = io.req_in0;
  assign in1     = io.req_in1;
  assign fn      = io.req_fn;
  assign sh      = in1[SW-1:0];
  assign sum     = in0 + in1;
  assign eq      = in0 == in1;
  assign lt      = $signed(in0) < $signed(in1);
  assign ltu     = in0 < in1;
  assign is_iter = fn >= 5'd13 && fn <= 5'd20;
  assign is_mul  = fn <= 5'd16;
  // Signed flavours: MULH/MULHSU/DIV/REM treat in0 as signed; MULH/DIV/REM treat in1 as signed.
  assign s0      = (fn == 5'd14 || fn == 5'd15 || fn == 5'd17 || fn == 5'd19) && in0[N-1];
  assign s1      = (fn == 5'd14 || fn == 5'd17 || fn == 5'd19) && in1[N-1];
  assign mag0    = s0 ? -in0 : in0;
  assign mag1    = s1 ? -in1 : in1;
  always_comb begin
    alu_d = '0;
    case (fn)
      5'd0:  alu_d = sum;
      5'd1:  alu_d = in0 - in1;
      5'd2:  alu_d = in0 & in1;
      5'd3:  alu_d = in0 | in1;
      5'd4:  alu_d = in0 ^ in1;
      5'd5:  alu_d = N'(lt);
      5'd6:  alu_d = N'(ltu);
      5'd7:  alu_d = $signed(in0) >>> sh;
      5'd8:  alu_d = in0 >> sh;
      5'd9:  alu_d = in0 << sh;
      5'd10: alu_d = {sum[N-1:1], 1'b0};
      5'd11: alu_d = in0;
      5'd12: alu_d = in1;
      default: alu_d = '0;
    endcase
  end
  // Multiply: shift-add with the multiplier in the low half of p_q, partial product in the high half.
  assign madd  = {1'b0, p_q[2*N-1:N]} + (p_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
  // Divide: restoring step, remainder in the high half, dividend shifting out / quotient shifting in low.
  assign rsh   = {p_q[2*N-1:N], p_q[N-1]};
  assign rdiff = rsh - {1'b0, b_q};
  assign p_d   = mul_q ? {madd, p_q[N-1:1]}
               : rdiff[N] ? {rsh[N-1:0], p_q[N-2:0], 1'b0} : {rdiff[N-1:0], p_q[N-2:0], 1'b1};
  assign prod  = nq_q ? -p_d : p_d;
  assign quo   = p_d[N-1:0];
  assign rem   = p_d[2*N-1:N];
  assign fin_d = fn_q == 5'd13 ? prod[N-1:0]
               : fn_q <= 5'd16 ? prod[2*N-1:N]
               : fn_q <= 5'd18 ? (dz_q ? '1 : nq_q ? -quo : quo)
               : (dz_q ? in0_q : nr_q ? -rem : rem);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      fn_q    <= '0;
      in0_q   <= '0;
      b_q     <= '0;
      p_q     <= '0;
      mul_q   <= 1'b0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      dz_q    <= 1'b0;
      out_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (io.req_val && rdy_q) begin
            rdy_q <= 1'b0;
            fn_q  <= fn;
            in0_q <= in0;
            eq_q  <= eq;
            lt_q  <= lt;
            ltu_q <= ltu;
            if (is_iter) begin
              state_q <= CALC;
              cnt_q   <= CW'(N);
              mul_q   <= is_mul;
              b_q     <= is_mul ? mag0 : mag1;
              p_q     <= {{N{1'b0}}, is_mul ? mag1 : mag0};
              nq_q    <= s0 ^ s1;
              nr_q    <= s0;
              dz_q    <= !is_mul && in1 == '0;
            end else begin
              state_q <= DONE;
              out_q   <= alu_d;
            end
          end
        end
        CALC: begin
          p_q   <= p_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            out_q   <= fin_d;
          end
        end
        DONE: begin
          if (io.resp_rdy) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign io.req_rdy  = rdy_q;
  assign io.resp_val = state_q == DONE;
  assign io.resp_out = out_q;
  assign io.resp_eq  = eq_q;
  assign io.resp_lt  = lt_q;
  assign io.resp_ltu = ltu_q;
endmodule

// File: tb/tb_proc_dpath_alu_iter.sv
// tb_proc_dpath_alu_iter: scoreboard bench for the iterative ALU at 32 and 8 bits.
module tb_proc_dpath_alu_iter;
  typedef struct packed {
    logic [4:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } op_t;
  typedef struct {
    logic [34:0] v;
    int          lat;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        req_val = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [4:0]  req_fn = '0;
  logic [31:0] req_in0 = '0;
  logic [31:0] req_in1 = '0;
  logic        rv_m, rdy_m, eq_m, lt_m, ltu_m;
  logic [31:0] out_m;
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  proc_dpath_alu_iter_if #(.p_nbits(32)) i32 ();
  proc_dpath_alu_iter_if #(.p_nbits(8))  i8 ();
  proc_dpath_alu_iter #(.p_nbits(32)) dut32 (.clk(clk), .reset(reset), .io(i32));
  proc_dpath_alu_iter #(.p_nbits(8))  dut8  (.clk(clk), .reset(reset), .io(i8));
  assign i32.req_val  = req_val & ~sel;
  assign i32.req_fn   = req_fn;
  assign i32.req_in0  = req_in0;
  assign i32.req_in1  = req_in1;
  assign i32.resp_rdy = resp_rdy & ~sel;
  assign i8.req_val   = req_val & sel;
  assign i8.req_fn    = req_fn;
  assign i8.req_in0   = req_in0[7:0];
  assign i8.req_in1   = req_in1[7:0];
  assign i8.resp_rdy  = resp_rdy & sel;
  assign rv_m  = sel ? i8.resp_val : i32.resp_val;
  assign rdy_m = sel ? i8.req_rdy  : i32.req_rdy;
  assign out_m = sel ? {24'b0, i8.resp_out} : i32.resp_out;
  assign eq_m  = sel ? i8.resp_eq  : i32.resp_eq;
  assign lt_m  = sel ? i8.resp_lt  : i32.resp_lt;
  assign ltu_m = sel ? i8.resp_ltu : i32.resp_ltu;
  always #5 clk = ~clk;
  function automatic logic [2:0] flags(input logic [31:0] a, input logic [31:0] b);
    return {a == b, $signed(a) < $signed(b), a < b};
  endfunction
  function automatic logic [31:0] model(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    logic [63:0] up = {32'b0, a} * {32'b0, b};
    logic [63:0] sp = sa * sb;
    logic [63:0] su = sa * ub;
    logic [4:0]  sh = b[4:0];
    logic [31:0] s = a + b;
    longint      q;
    case (fn)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return {31'b0, $signed(a) < $signed(b)};
      5'd6:  return {31'b0, a < b};
      5'd7:  return $signed(a) >>> sh;
      5'd8:  return a >> sh;
      5'd9:  return a << sh;
      5'd10: return s & ~32'd1;
      5'd11: return a;
      5'd12: return b;
      5'd13: return up[31:0];
      5'd14: return sp[63:32];
      5'd15: return su[63:32];
      5'd16: return up[63:32];
      5'd17: begin if (b == 0) return '1; q = sa / sb; return q[31:0]; end
      5'd18: begin if (b == 0) return '1; return a / b; end
      5'd19: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      5'd20: begin if (b == 0) return a; return a % b; end
      default: return '0;
    endcase
  endfunction
  task automatic xfer(input bit s, input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input int hold, output logic [34:0] got, output int lat, output bit stable);
    int w = 0;
    @(negedge clk);
    sel = s; req_fn = fn; req_in0 = a; req_in1 = b; req_val = 1'b1;
    while (!rdy_m && w < 100) begin @(negedge clk); w++; end
    lat = 0;
    do begin @(negedge clk); req_val = 1'b0; lat++; end while (!rv_m && lat < 100);
    got = {out_m, eq_m, lt_m, ltu_m};
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      stable &= rv_m && !rdy_m && ({out_m, eq_m, lt_m, ltu_m} === got);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({i32.resp_val, i32.req_rdy, i32.resp_out, i32.resp_eq, i32.resp_lt, i32.resp_ltu} !== '0)
      $display("FAIL reset32 got rv=%b rdy=%b out=%h", i32.resp_val, i32.req_rdy, i32.resp_out);
    else n_pass++;
    n_chk++;
    if ({i8.resp_val, i8.req_rdy, i8.resp_out, i8.resp_eq, i8.resp_lt, i8.resp_ltu} !== '0)
      $display("FAIL reset8 got rv=%b rdy=%b out=%h", i8.resp_val, i8.req_rdy, i8.resp_out);
    else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({i32.req_rdy, i8.req_rdy, i32.resp_val, i8.resp_val} !== 4'b1100)
      $display("FAIL reset_release got rdy32=%b rdy8=%b rv32=%b rv8=%b exp 1 1 0 0",
               i32.req_rdy, i8.req_rdy, i32.resp_val, i8.resp_val);
    else n_pass++;
  endtask
  task automatic test_hold();
    logic [34:0] got;
    int          lat;
    bit          st;
    exp_t        e;
    e.v = {32'h80000000, 3'b000}; e.lat = 1;
    sb.push_back(e);
    xfer(1'b0, 5'd0, 32'h7FFFFFFF, 32'h1, 3, got, lat, st);
    e = sb.pop_front();
    n_chk++;
    if (got !== e.v) $display("FAIL hold_add got %h exp %h", got, e.v); else n_pass++;
    n_chk++;
    if (lat !== e.lat) $display("FAIL hold_lat got %0d exp %0d", lat, e.lat); else n_pass++;
    n_chk++;
    if (st !== 1'b1) $display("FAIL hold_stable got %b exp 1", st); else n_pass++;
  endtask
  task automatic test_single();
    op_t ops[15] = '{
      '{5'd7,  32'h80000000, 32'h00000024, 32'hF8000000},
      '{5'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
      '{5'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
      '{5'd10, 32'h00001001, 32'h00000000, 32'h00001000},
      '{5'd0,  32'hFFFFFFFF, 32'h00000002, 32'h00000001},
      '{5'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE},
      '{5'd1,  32'h00000009, 32'h00000009, 32'h00000000},
      '{5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000},
      '{5'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0},
      '{5'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0},
      '{5'd8,  32'h80000000, 32'h0000001F, 32'h00000001},
      '{5'd9,  32'h00000003, 32'h00000004, 32'h00000030},
      '{5'd11, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF},
      '{5'd12, 32'hDEADBEEF, 32'h12345678, 32'h12345678},
      '{5'd25, 32'h00000001, 32'h00000002, 32'h00000000}
    };
    logic [34:0] got;
    int          lat;
    bit          st;
    exp_t        e;
    foreach (ops[i]) begin
      e.v = {ops[i].exp, flags(ops[i].a, ops[i].b)}; e.lat = 1;
      sb.push_back(e);
      xfer(1'b0, ops[i].fn, ops[i].a, ops[i].b, 0, got, lat, st);
      e = sb.pop_front();
      n_chk++;
      if (got !== e.v) $display("FAIL single fn%0d got %h exp %h", ops[i].fn, got, e.v); else n_pass++;
      n_chk++;
      if (lat !== e.lat) $display("FAIL single_lat fn%0d got %0d exp %0d", ops[i].fn, lat, e.lat); else n_pass++;
    end
  endtask
  task automatic test_muldiv();
    op_t ops[15] = '{
      '{5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
      '{5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
      '{5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
      '{5'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{5'd13, 32'h00003039, 32'h00001A85, 32'h04FED79D},
      '{5'd17, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
      '{5'd19, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
      '{5'd18, 32'h00000064, 32'h00000000, 32'hFFFFFFFF},
      '{5'd20, 32'h00000064, 32'h00000000, 32'h00000064},
      '{5'd17, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
      '{5'd19, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
      '{5'd17, 32'h00000007, 32'h00000000, 32'hFFFFFFFF},
      '{5'd19, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9},
      '{5'd18, 32'h000003E8, 32'h00000007, 32'h0000008E},
      '{5'd20, 32'h000003E8, 32'h00000007, 32'h00000006}
    };
    logic [34:0] got;
    int          lat;
    bit          st;
    exp_t        e;
    foreach (ops[i]) begin
      e.v = {ops[i].exp, flags(ops[i].a, ops[i].b)}; e.lat = 33;
      sb.push_back(e);
      xfer(1'b0, ops[i].fn, ops[i].a, ops[i].b, 0, got, lat, st);
      e = sb.pop_front();
      n_chk++;
      if (got !== e.v) $display("FAIL muldiv fn%0d got %h exp %h", ops[i].fn, got, e.v); else n_pass++;
      n_chk++;
      if (lat !== e.lat) $display("FAIL muldiv_lat fn%0d got %0d exp %0d", ops[i].fn, lat, e.lat); else n_pass++;
    end
  endtask
  task automatic test_back_to_back();
    logic [34:0] got;
    int          lat;
    bit          st;
    exp_t        e;
    logic [4:0]  fn;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      fn = 5'($urandom_range(0, 22));
      a  = $urandom;
      b  = (i % 5 == 0) ? 32'h0 : $urandom;
      e.v = {model(fn, a, b), flags(a, b)};
      e.lat = (fn >= 5'd13 && fn <= 5'd20) ? 33 : 1;
      sb.push_back(e);
      xfer(1'b0, fn, a, b, i % 3, got, lat, st);
      e = sb.pop_front();
      n_chk++;
      if (got !== e.v) $display("FAIL b2b fn%0d a=%h b=%h got %h exp %h", fn, a, b, got, e.v); else n_pass++;
      n_chk++;
      if (lat !== e.lat || st !== 1'b1) $display("FAIL b2b_lat fn%0d got %0d/%b exp %0d/1", fn, lat, st, e.lat); else n_pass++;
    end
  endtask
  task automatic test_reset_mid();
    logic [34:0] got;
    int          lat;
    bit          st;
    bit          quiet = 1'b1;
    exp_t        e;
    @(negedge clk);
    sel = 1'b0; req_fn = 5'd17; req_in0 = 32'hFFFFFFF9; req_in1 = 32'h2; req_val = 1'b1;
    @(negedge clk);
    req_val = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++;
    if ({i32.resp_val, i32.req_rdy, i32.resp_out, i32.resp_eq, i32.resp_lt, i32.resp_ltu} !== '0)
      $display("FAIL midreset got rv=%b rdy=%b out=%h flags=%b%b%b", i32.resp_val, i32.req_rdy,
               i32.resp_out, i32.resp_eq, i32.resp_lt, i32.resp_ltu);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({i32.req_rdy, i32.resp_val} !== 2'b10)
      $display("FAIL midreset_release got rdy=%b rv=%b exp 1 0", i32.req_rdy, i32.resp_val);
    else n_pass++;
    repeat (40) begin @(negedge clk); quiet &= !i32.resp_val; end
    n_chk++;
    if (quiet !== 1'b1) $display("FAIL midreset_stale got resp_val seen exp none"); else n_pass++;
    e.v = {32'h5, flags(32'h2, 32'h3)}; e.lat = 1;
    sb.push_back(e);
    xfer(1'b0, 5'd0, 32'h2, 32'h3, 0, got, lat, st);
    e = sb.pop_front();
    n_chk++;
    if (got !== e.v) $display("FAIL midreset_add got %h exp %h", got, e.v); else n_pass++;
    n_chk++;
    if (lat !== e.lat) $display("FAIL midreset_lat got %0d exp %0d", lat, e.lat); else n_pass++;
  endtask
  task automatic test_p8();
    logic [34:0] got;
    int          lat;
    bit          st;
    exp_t        e;
    e.v = {32'hFE, 3'b100}; e.lat = 9;
    sb.push_back(e);
    xfer(1'b1, 5'd16, 32'hFF, 32'hFF, 0, got, lat, st);
    e = sb.pop_front();
    n_chk++;
    if (got !== e.v) $display("FAIL p8_mulhu got %h exp %h", got, e.v); else n_pass++;
    n_chk++;
    if (lat !== e.lat) $display("FAIL p8_mulhu_lat got %0d exp %0d", lat, e.lat); else n_pass++;
    e.v = {32'h08, 3'b011}; e.lat = 1;
    sb.push_back(e);
    xfer(1'b1, 5'd9, 32'h01, 32'h0B, 0, got, lat, st);
    e = sb.pop_front();
    n_chk++;
    if (got !== e.v) $display("FAIL p8_sll got %h exp %h", got, e.v); else n_pass++;
    n_chk++;
    if (lat !== e.lat) $display("FAIL p8_sll_lat got %0d exp %0d", lat, e.lat); else n_pass++;
    sel = 1'b0;
  endtask
  initial begin
    test_reset();
    test_hold();
    test_single();
    test_muldiv();
    test_back_to_back();
    test_reset_mid();
    test_p8();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
